// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants and types for the ME reference bank loader
package me_pkg;

  localparam int PIXEL    = 8;
  localparam int IN_PIX   = 4;
  localparam int WORD_PIX = 2 * IN_PIX;
  localparam int DEPTH    = 96;
  localparam int AW       = 7;

  localparam int BEAT_W = IN_PIX * PIXEL;
  localparam int WORD_W = WORD_PIX * PIXEL;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FREE = 2'd1,
    FILL      = 2'd2
  } state_t;

  typedef logic bank_id_t;

  // One-hot mask for a bank id, used to address the bank_full pair.
  function automatic logic [1:0] bank_onehot(input bank_id_t b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pix_packer.sv
// rtl/pix_packer.sv - packs pairs of accepted 4-pixel beats into 8-pixel bank words
module pix_packer
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic [AW-1:0]     word_addr,
  output logic              word_accept,
  output logic [WORD_W-1:0] word_data,
  output logic [AW-1:0]     word_address,
  output logic              word_wr
);

  logic [BEAT_W-1:0] hold_reg;
  logic              half;

  // An accepted beat completes a word when the first half is already held.
  assign word_accept = beat_valid && half;

  // First beat is parked in hold_reg; second beat emits the word one cycle later.
  // Data and address keep their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg     <= '0;
      half         <= 1'b0;
      word_data    <= '0;
      word_address <= '0;
      word_wr      <= 1'b0;
    end else begin
      word_wr <= 1'b0;
      if (beat_valid) begin
        if (!half) begin
          hold_reg <= beat_data;
          half     <= 1'b1;
        end else begin
          word_data    <= {hold_reg, beat_data};
          word_address <= word_addr;
          word_wr      <= 1'b1;
          half         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ref_bank_loader.sv
// rtl/ref_bank_loader.sv - ping-pong reference bank write controller
module ref_bank_loader
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [BEAT_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [WORD_W-1:0] ref_in,
  output logic [AW-1:0]     write_address,
  output logic              wr_en,
  output logic              Bank_sel,
  input  logic [1:0]        bank_release,
  output logic [1:0]        bank_full,
  output logic              fill_done
);

  state_t      state;
  logic [AW-1:0] word_cnt;
  logic        beat_acc;
  logic        word_acc;
  logic        last_write;
  logic [1:0]  set_mask;

  // word_cnt reaches DEPTH once the last word's second beat is taken, which
  // closes the input until the final write retires and the fill wraps up.
  assign pix_ready  = (state == FILL) && (word_cnt < AW'(DEPTH));
  assign beat_acc   = pix_valid && pix_ready;
  assign last_write = wr_en && (write_address == AW'(DEPTH - 1));
  assign set_mask   = last_write ? bank_onehot(Bank_sel) : 2'b00;

  pix_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_valid   (beat_acc),
    .beat_data    (pix_data),
    .word_addr    (word_cnt),
    .word_accept  (word_acc),
    .word_data    (ref_in),
    .word_address (write_address),
    .word_wr      (wr_en)
  );

  // Fill sequencing, word counting and per-bank full tracking (set beats release).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      Bank_sel  <= 1'b0;
      bank_full <= 2'b00;
      fill_done <= 1'b0;
    end else begin
      fill_done <= last_write;
      bank_full <= (bank_full & ~bank_release) | set_mask;
      if (word_acc) begin
        word_cnt <= word_cnt + AW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= bank_full[Bank_sel] ? WAIT_FREE : FILL;
          end
        end
        WAIT_FREE: begin
          if (bank_release[Bank_sel]) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (last_write) begin
            state    <= IDLE;
            word_cnt <= '0;
            Bank_sel <= ~Bank_sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
